mem_access_unit: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline outputs: decodes MemRW_MEM, drives the data-memory request/grant/rvalid handshake, aligns load data and sign-extends it, and generates stall_MEM back to the hazard logic for multi-cycle accesses.
- Registers the MEM/WB pipeline fields, so it also serves as the MEM/WB boundary.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/load_align.sv | 24 ++
 rtl/mem_access_unit.sv | 130 +++++++++++++
 tb/tb_mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline codes: MemRW access codes, MEM FSM states, ResultSrc selects
package pipe_pkg;

   localparam logic [2:0] MEMRW_NONE = 3'b000;
   localparam logic [2:0] MEMRW_LW   = 3'b001;
   localparam logic [2:0] MEMRW_SW   = 3'b010;
   localparam logic [2:0] MEMRW_LB   = 3'b011;
   localparam logic [2:0] MEMRW_LBU  = 3'b100;
   localparam logic [2:0] MEMRW_SB   = 3'b101;

   localparam logic [1:0] RESULTSRC_ALU = 2'b00;
   localparam logic [1:0] RESULTSRC_MEM = 2'b01;
   localparam logic [1:0] RESULTSRC_PC4 = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_GNT = 2'd1,
      ST_WAIT_RD  = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic        regwrite;
      logic [1:0]  resultsrc;
      logic [31:0] pcadd4;
      logic [31:0] alu_result;
      logic [31:0] readdata;
      logic [4:0]  rac;
   } memwb_t;

   function automatic logic is_load(input logic [2:0] code);
      return (code == MEMRW_LW) || (code == MEMRW_LB) || (code == MEMRW_LBU);
   endfunction

   function automatic logic is_store(input logic [2:0] code);
      return (code == MEMRW_SW) || (code == MEMRW_SB);
   endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends load data from a 32-bit read word by lane and access code
module load_align
   import pipe_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  code_i,
   output logic [31:0] result_o
);

   logic [7:0] byte_v;

   always_comb begin
      byte_v   = rdata_i[{lane_i, 3'b000} +: 8];
      result_o = 32'h0;
      case (code_i)
         MEMRW_LW:  result_o = rdata_i;
         MEMRW_LB:  result_o = {{24{byte_v[7]}}, byte_v};
         MEMRW_LBU: result_o = {24'h0, byte_v};
         default:   result_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage data-memory handshake plus MEM/WB register; MEM_MISALIGN_TRAP_EN adds the word-misalign trap
module mem_access_unit
   import pipe_pkg::*;
#(
   parameter int ADDR_W = 32
)
(
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              RegWrite_MEM,
   input  logic [2:0]        MemRW_MEM,
   input  logic [1:0]        ResultSrc_MEM,
   input  logic [31:0]       PCadd4_MEM,
   input  logic [31:0]       ALU_result_MEM,
   input  logic [31:0]       RD2_MEM,
   input  logic [4:0]        rac_MEM,
   input  logic              flush_MEMWB,
   output logic              stall_MEM,
   output logic              DMEM_REQ,
   output logic              DMEM_WE,
   output logic [ADDR_W-1:0] DMEM_ADDR,
   output logic [31:0]       DMEM_WDATA,
   output logic [3:0]        DMEM_BE,
   input  logic              DMEM_GNT,
   input  logic              DMEM_RVALID,
   input  logic [31:0]       DMEM_RDATA,
   output logic              RegWrite_WB,
   output logic [1:0]        ResultSrc_WB,
   output logic [31:0]       PCadd4_WB,
   output logic [31:0]       ALU_result_WB,
   output logic [31:0]       ReadData_WB,
   output logic [4:0]        rac_WB
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic              misalign_MEM
`endif
);

   mem_state_t  state_q, state_d;
   memwb_t      wb_q, wb_d;
   logic [1:0]  lane;
   logic        ld, st, misalign, pending, complete;
   logic [31:0] load_data;

   assign lane = ALU_result_MEM[1:0];

   always_comb begin
      ld = is_load(MemRW_MEM);
      st = is_store(MemRW_MEM);
`ifdef MEM_MISALIGN_TRAP_EN
      misalign = ((MemRW_MEM == MEMRW_LW) || (MemRW_MEM == MEMRW_SW)) && (lane != 2'b00);
`else
      misalign = 1'b0;
`endif
      // Gating with RSTN keeps REQ and stall low for the whole reset window.
      pending  = RSTN && (ld || st) && !misalign;
      complete = (state_q == ST_WAIT_RD) ? DMEM_RVALID : (DMEM_GNT && st);
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_MEM = misalign;
`endif

   assign stall_MEM = pending && !complete;
   assign DMEM_REQ  = pending && (state_q != ST_WAIT_RD);

   // Request fields are zero whenever no request is presented.
   always_comb begin
      DMEM_WE    = 1'b0;
      DMEM_ADDR  = '0;
      DMEM_BE    = 4'h0;
      DMEM_WDATA = 32'h0;
      if (DMEM_REQ) begin
         DMEM_WE    = st;
         DMEM_ADDR  = {ALU_result_MEM[ADDR_W-1:2], 2'b00};
         DMEM_BE    = (MemRW_MEM == MEMRW_SB) ? (4'b0001 << lane) : 4'b1111;
         DMEM_WDATA = (MemRW_MEM == MEMRW_SB) ? {4{RD2_MEM[7:0]}} : RD2_MEM;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_WAIT_GNT: begin
            if (!pending)      state_d = ST_IDLE;
            else if (DMEM_GNT) state_d = ld ? ST_WAIT_RD : ST_IDLE;
            else               state_d = ST_WAIT_GNT;
         end
         ST_WAIT_RD: if (DMEM_RVALID || !pending) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   load_align u_load_align (
      .rdata_i  (DMEM_RDATA),
      .lane_i   (lane),
      .code_i   (MemRW_MEM),
      .result_o (load_data)
   );

   always_comb begin
      wb_d = '0;
      if (!flush_MEMWB && !stall_MEM) begin
         wb_d.regwrite   = RegWrite_MEM && !misalign;
         wb_d.resultsrc  = ResultSrc_MEM;
         wb_d.pcadd4     = PCadd4_MEM;
         wb_d.alu_result = ALU_result_MEM;
         wb_d.readdata   = ld ? load_data : 32'h0;
         wb_d.rac        = rac_MEM;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= ST_IDLE;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         wb_q    <= wb_d;
      end
   end

   assign RegWrite_WB   = wb_q.regwrite;
   assign ResultSrc_WB  = wb_q.resultsrc;
   assign PCadd4_WB     = wb_q.pcadd4;
   assign ALU_result_WB = wb_q.alu_result;
   assign ReadData_WB   = wb_q.readdata;
   assign rac_WB        = wb_q.rac;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit; honours MEM_MISALIGN_TRAP_EN
module tb_mem_access_unit;

   localparam logic [2:0] C_NONE = 3'd0, C_LW = 3'd1, C_SW = 3'd2, C_LB = 3'd3, C_LBU = 3'd4, C_SB = 3'd5;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic        RegWrite_MEM, flush_MEMWB, DMEM_GNT, DMEM_RVALID;
   logic [2:0]  MemRW_MEM;
   logic [1:0]  ResultSrc_MEM;
   logic [31:0] PCadd4_MEM, ALU_result_MEM, RD2_MEM, DMEM_RDATA;
   logic [4:0]  rac_MEM;
   logic        stall_MEM, DMEM_REQ, DMEM_WE, RegWrite_WB;
   logic [31:0] DMEM_ADDR, DMEM_WDATA, PCadd4_WB, ALU_result_WB, ReadData_WB;
   logic [3:0]  DMEM_BE;
   logic [1:0]  ResultSrc_WB;
   logic [4:0]  rac_WB;
   logic        misalign_MEM;

   mem_access_unit #(.ADDR_W(32)) dut (
      .CLK(CLK), .RSTN(RSTN), .RegWrite_MEM(RegWrite_MEM), .MemRW_MEM(MemRW_MEM),
      .ResultSrc_MEM(ResultSrc_MEM), .PCadd4_MEM(PCadd4_MEM), .ALU_result_MEM(ALU_result_MEM),
      .RD2_MEM(RD2_MEM), .rac_MEM(rac_MEM), .flush_MEMWB(flush_MEMWB), .stall_MEM(stall_MEM),
      .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
      .DMEM_BE(DMEM_BE), .DMEM_GNT(DMEM_GNT), .DMEM_RVALID(DMEM_RVALID), .DMEM_RDATA(DMEM_RDATA),
      .RegWrite_WB(RegWrite_WB), .ResultSrc_WB(ResultSrc_WB), .PCadd4_WB(PCadd4_WB),
      .ALU_result_WB(ALU_result_WB), .ReadData_WB(ReadData_WB), .rac_WB(rac_WB)
`ifdef MEM_MISALIGN_TRAP_EN
      , .misalign_MEM(misalign_MEM)
`endif
   );

`ifndef MEM_MISALIGN_TRAP_EN
   assign misalign_MEM = 1'b0;
`endif

   always #5 CLK = ~CLK;

   int n_checks = 0, n_errors = 0;
   int req_seen, stall_seen, mis_seen;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;
   logic        chk_en = 1'b0;

   // current instruction, as seen by the model
   logic [2:0]  c_code;
   logic [31:0] c_addr, c_rd2, c_pc, c_rdata;
   logic [4:0]  c_rac;
   logic        c_rw, c_flush;
   logic [1:0]  c_rs;
   logic        exp_req, exp_stall, exp_mis;
   logic        e_rw;
   logic [1:0]  e_rs;
   logic [31:0] e_pc, e_alu, e_rd;
   logic [4:0]  e_rac;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic f_mis(input logic [2:0] code, input logic [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
      return (code == C_LW || code == C_SW) && (addr[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic f_ld(input logic [2:0] code);
      return code == C_LW || code == C_LB || code == C_LBU;
   endfunction

   function automatic logic f_st(input logic [2:0] code);
      return code == C_SW || code == C_SB;
   endfunction

   function automatic logic [31:0] f_align(input logic [2:0] code, input logic [31:0] w, input logic [1:0] lane);
      logic [31:0] b;
      b = (w >> (lane * 8)) & 32'hFF;
      if (code == C_LW) return w;
      if (code == C_LBU) return b;
      if (code == C_LB) return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      return 32'h0;
   endfunction

   // MEM/WB model: a retiring instruction lands in WB, everything else is a zero bubble
   always @(posedge CLK or negedge RSTN) begin
      if (!RSTN || c_flush || exp_stall) begin
         e_rw = 0; e_rs = 0; e_pc = 0; e_alu = 0; e_rd = 0; e_rac = 0;
      end else begin
         e_rw  = c_rw && !f_mis(c_code, c_addr);
         e_rs  = c_rs;
         e_pc  = c_pc;
         e_alu = c_addr;
         e_rd  = f_ld(c_code) ? f_align(c_code, c_rdata, c_addr[1:0]) : 32'h0;
         e_rac = c_rac;
      end
   end

   always @(negedge CLK) begin
      #2;
      if (chk_en) begin
         chk("req", DMEM_REQ, exp_req);
         chk("stall", stall_MEM, exp_stall);
`ifdef MEM_MISALIGN_TRAP_EN
         chk("misalign", misalign_MEM, exp_mis);
`endif
         if (exp_req) begin
            chk("addr", DMEM_ADDR, {c_addr[31:2], 2'b00});
            chk("we", DMEM_WE, f_st(c_code));
            chk("be", DMEM_BE, (c_code == C_SB) ? (4'b0001 << c_addr[1:0]) : 4'b1111);
            if (f_st(c_code))
               chk("wdata", DMEM_WDATA, (c_code == C_SB) ? {4{c_rd2[7:0]}} : c_rd2);
         end
         chk("wb_rw", RegWrite_WB, e_rw);
         chk("wb_rs", ResultSrc_WB, e_rs);
         chk("wb_pc", PCadd4_WB, e_pc);
         chk("wb_alu", ALU_result_WB, e_alu);
         chk("wb_rd", ReadData_WB, e_rd);
         chk("wb_rac", rac_WB, e_rac);
         if (DMEM_REQ) begin
            req_seen++;
            last_addr = DMEM_ADDR; last_be = DMEM_BE; last_wdata = DMEM_WDATA;
         end
         if (stall_MEM) stall_seen++;
         if (misalign_MEM) mis_seen++;
      end
   end

   task automatic set_instr(input logic [2:0] code, input logic [31:0] addr, rd2, pc,
                            input logic [4:0] rac, input logic rw, input logic [1:0] rs);
      c_code = code; c_addr = addr; c_rd2 = rd2; c_pc = pc; c_rac = rac; c_rw = rw; c_rs = rs;
      MemRW_MEM = code; ALU_result_MEM = addr; RD2_MEM = rd2; PCadd4_MEM = pc;
      rac_MEM = rac; RegWrite_MEM = rw; ResultSrc_MEM = rs; flush_MEMWB = c_flush;
   endtask

   // Runs one instruction; memory grants after gd cycles, load data arrives rd cycles after the grant cycle + 1.
   task automatic do_instr(input logic [2:0] code, input logic [31:0] addr, rd2, pc,
                           input logic [4:0] rac, input logic rw, input logic [1:0] rs,
                           input logic [31:0] rdata, input int gd, input int rd);
      logic acc, ld, st;
      bit done;
      int k;
      req_seen = 0; stall_seen = 0; mis_seen = 0;
      set_instr(code, addr, rd2, pc, rac, rw, rs);
      c_rdata = rdata;
      acc = (f_ld(code) || f_st(code)) && !f_mis(code, addr);
      ld = acc && f_ld(code);
      st = acc && f_st(code);
      k = 0; done = 0;
      while (!done) begin
         DMEM_GNT    = acc && (k == gd);
         DMEM_RVALID = ld && (k == gd + 1 + rd);
         DMEM_RDATA  = DMEM_RVALID ? rdata : (32'h5A5A_0000 | k);
         exp_req     = acc && (k <= gd);
         exp_stall   = acc && (st ? (k < gd) : (k < gd + 1 + rd));
         exp_mis     = f_mis(code, addr);
         done        = !exp_stall;
         @(negedge CLK);
         k++;
         if (k > 64) begin
            chk("cycle_bound", k, 64);
            done = 1;
         end
      end
      DMEM_GNT = 0; DMEM_RVALID = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      RSTN = 0; c_flush = 0; DMEM_GNT = 0; DMEM_RVALID = 0; DMEM_RDATA = 0;
      exp_req = 0; exp_stall = 0; exp_mis = 0; c_rdata = 0;
      set_instr(C_NONE, 0, 0, 0, 0, 0, 0);
      chk_en = 1;
      @(negedge CLK);
      @(negedge CLK);
      RSTN = 1;
      @(negedge CLK);

      do_instr(C_LW, 32'h100, 0, 32'h104, 5'd5, 1, pipe_pkg::RESULTSRC_MEM, 32'hDEADBEEF, 0, 0);
      chk("lw_stall_cycles", stall_seen, 1);
      chk("lw_readdata_lit", ReadData_WB, 32'hDEADBEEF);
      chk("lw_rac_lit", rac_WB, 5);
      chk("lw_rw_lit", RegWrite_WB, 1);

      do_instr(C_SB, 32'h203, 32'h0000_00A5, 32'h108, 5'd0, 0, pipe_pkg::RESULTSRC_ALU, 0, 3, 0);
      chk("sb_req_cycles", req_seen, 4);
      chk("sb_stall_cycles", stall_seen, 3);
      chk("sb_addr_lit", last_addr, 32'h200);
      chk("sb_be_lit", last_be, 4'b1000);
      chk("sb_wdata_lit", last_wdata, 32'hA5A5A5A5);

      do_instr(C_LB, 32'h102, 0, 32'h10C, 5'd7, 1, pipe_pkg::RESULTSRC_MEM, 32'h0080FF00, 1, 2);
      chk("lb_lit", ReadData_WB, 32'hFFFFFF80);
      chk("lb_stall_cycles", stall_seen, 4);
      do_instr(C_LBU, 32'h102, 0, 32'h110, 5'd8, 1, pipe_pkg::RESULTSRC_MEM, 32'h0080FF00, 0, 0);
      chk("lbu_lit", ReadData_WB, 32'h00000080);
      do_instr(C_LB, 32'h101, 0, 32'h114, 5'd9, 1, pipe_pkg::RESULTSRC_MEM, 32'h1234_7F00, 0, 1);
      chk("lb_pos_lit", ReadData_WB, 32'h0000007F);

      // back-to-back LW, SW, none
      do_instr(C_LW, 32'h040, 0, 32'h200, 5'd10, 1, pipe_pkg::RESULTSRC_MEM, 32'hCAFE_F00D, 0, 0);
      chk("b2b_lw_req", req_seen, 1);
      do_instr(C_SW, 32'h010, 32'h1122_3344, 32'h204, 5'd11, 0, pipe_pkg::RESULTSRC_ALU, 0, 0, 0);
      chk("b2b_sw_req", req_seen, 1);
      chk("b2b_sw_stall", stall_seen, 0);
      do_instr(C_NONE, 32'h0000_0ABC, 32'h55, 32'h208, 5'd12, 1, pipe_pkg::RESULTSRC_ALU, 0, 0, 0);
      chk("b2b_none_req", req_seen, 0);
      chk("b2b_none_alu_lit", ALU_result_WB, 32'h0000_0ABC);
      do_instr(3'b110, 32'h44, 32'h66, 32'h20C, 5'd13, 1, pipe_pkg::RESULTSRC_PC4, 0, 0, 0);
      chk("reserved_req", req_seen, 0);
      do_instr(C_SB, 32'h300, 32'h0000_003C, 32'h210, 5'd0, 0, pipe_pkg::RESULTSRC_ALU, 0, 0, 0);
      chk("sb_lane0_be_lit", last_be, 4'b0001);

      c_flush = 1;
      do_instr(C_LW, 32'h080, 0, 32'h214, 5'd14, 1, pipe_pkg::RESULTSRC_MEM, 32'h0BAD_0BAD, 1, 1);
      chk("flush_rw_lit", RegWrite_WB, 0);
      c_flush = 0;

      do_instr(C_LW, 32'h101, 0, 32'h218, 5'd15, 1, pipe_pkg::RESULTSRC_MEM, 32'h7777_8888, 0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("mis_req_lit", req_seen, 0);
      chk("mis_flag_lit", mis_seen, 1);
      chk("mis_rw_lit", RegWrite_WB, 0);
`else
      chk("nomis_addr_lit", last_addr, 32'h100);
      chk("nomis_rd_lit", ReadData_WB, 32'h7777_8888);
`endif

      // reset while waiting for read data, then a stray RVALID while idle
      set_instr(C_LW, 32'h100, 0, 32'h300, 5'd20, 1, pipe_pkg::RESULTSRC_MEM);
      c_rdata = 32'h1111_2222;
      DMEM_GNT = 1; exp_req = 1; exp_stall = 1;
      @(negedge CLK);
      DMEM_GNT = 0; RSTN = 0; exp_req = 0; exp_stall = 0;
      @(negedge CLK);
      set_instr(C_NONE, 0, 0, 0, 0, 0, 0);
      RSTN = 1; DMEM_RVALID = 1; DMEM_RDATA = 32'hFFFF_FFFF;
      @(negedge CLK);
      DMEM_RVALID = 0;
      @(negedge CLK);
      chk("rst_wb_rw_lit", RegWrite_WB, 0);
      chk("rst_wb_rd_lit", ReadData_WB, 0);
      do_instr(C_LW, 32'h100, 0, 32'h304, 5'd21, 1, pipe_pkg::RESULTSRC_MEM, 32'h0123_4567, 0, 0);
      chk("post_rst_stall", stall_seen, 1);
      chk("post_rst_rd_lit", ReadData_WB, 32'h0123_4567);

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
